// File: rtl/output_writeback_pkg.sv
// rtl/output_writeback_pkg.sv - shared state encoding and default widths for output_writeback
//
// Purpose: FSM state type and default parameter values used by the
//          output_writeback top, its slot pipeline and its bus interface.
// Ports:   none (package).
package output_writeback_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int ADDR_WIDTH  = 16;
  localparam int COUNT_WIDTH = 16;
  localparam int BUFFER_SIZE = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/output_writeback_if.sv
// rtl/output_writeback_if.sv - job control, FIFO read and memory write signals of output_writeback
//
// Purpose: bundles the job control, FIFO read side and memory write side.
// Modports:
//   slave  - the writeback engine (sees Start/BaseAddr/NumWords/FifoReady/
//            FifoData/MemAck, drives Pop2/MemWrite/MemAddr/MemData/Busy/Done)
//   master - the surrounding system (opposite directions)
interface output_writeback_if
  import output_writeback_pkg::*;
#(
  parameter int DataWidth  = DATA_WIDTH,
  parameter int AddrWidth  = ADDR_WIDTH,
  parameter int CountWidth = COUNT_WIDTH,
  parameter int BufferSize = BUFFER_SIZE
);

  logic                  Start;
  logic [AddrWidth-1:0]  BaseAddr;
  logic [CountWidth-1:0] NumWords;
  logic [BufferSize-1:0] FifoReady;
  logic [DataWidth-1:0]  FifoData;
  logic                  Pop2;
  logic                  MemWrite;
  logic [AddrWidth-1:0]  MemAddr;
  logic [DataWidth-1:0]  MemData;
  logic                  MemAck;
  logic                  Busy;
  logic                  Done;

  modport slave (
    input  Start, BaseAddr, NumWords, FifoReady, FifoData, MemAck,
    output Pop2, MemWrite, MemAddr, MemData, Busy, Done
  );

  modport master (
    output Start, BaseAddr, NumWords, FifoReady, FifoData, MemAck,
    input  Pop2, MemWrite, MemAddr, MemData, Busy, Done
  );

endinterface

// File: rtl/output_writeback_slots.sv
// rtl/output_writeback_slots.sv - two-entry Next/Cur prefetch pipeline between FIFO and memory
//
// Purpose: Next holds the word most recently popped from the FIFO, Cur holds
//          the word currently offered to memory. Next advances into Cur when
//          Cur is empty or is being acknowledged, so a pop into Next and a
//          Next->Cur move may happen in the same cycle.
// Ports:
//   clk, aclr    clock, asynchronous active-high reset
//   push         FIFO pop strobe; push_data is captured into Next
//   push_data    FIFO head word
//   ack          memory acknowledge (only effective while Cur is valid)
//   next_valid   Next slot occupied
//   next_moves   Next transfers into Cur at the coming edge
//   cur_valid    Cur slot occupied (memory write request)
//   cur_data     Cur slot word (memory write data)
module output_writeback_slots
  import output_writeback_pkg::*;
#(
  parameter int DataWidth = DATA_WIDTH
) (
  input  logic                 clk,
  input  logic                 aclr,
  input  logic                 push,
  input  logic [DataWidth-1:0] push_data,
  input  logic                 ack,
  output logic                 next_valid,
  output logic                 next_moves,
  output logic                 cur_valid,
  output logic [DataWidth-1:0] cur_data
);

  logic [DataWidth-1:0] next_data;

  assign next_moves = next_valid & (~cur_valid | ack);

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      next_valid <= 1'b0;
      next_data  <= '0;
      cur_valid  <= 1'b0;
      cur_data   <= '0;
    end else begin
      // Cur: refill from Next takes priority over retiring on ack
      if (next_moves) begin
        cur_valid <= 1'b1;
        cur_data  <= next_data;
      end else if (cur_valid && ack) begin
        cur_valid <= 1'b0;
      end

      // Next: a fresh pop overwrites the slot even while it is moving out
      if (push) begin
        next_valid <= 1'b1;
        next_data  <= push_data;
      end else if (next_moves) begin
        next_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/output_writeback.sv
// rtl/output_writeback.sv - output FIFO read side: pops result words and writes them to memory
//
// Purpose: one job per accepted Start writes NumWords FIFO words to memory
//          at BaseAddr, BaseAddr+1, ... (wrapping), using a valid/ack
//          handshake. A two-entry prefetch sustains one write per cycle
//          while MemAck stays high.
// Ports:
//   clk   clock, all state on rising edge
//   aclr  asynchronous active-high reset
//   bus   output_writeback_if.slave: Start/BaseAddr/NumWords job control,
//         FifoReady/FifoData/Pop2 FIFO read, MemWrite/MemAddr/MemData/MemAck
//         memory write, Busy/Done status
module output_writeback
  import output_writeback_pkg::*;
#(
  parameter int DataWidth  = DATA_WIDTH,
  parameter int AddrWidth  = ADDR_WIDTH,
  parameter int CountWidth = COUNT_WIDTH
) (
  input  logic           clk,
  input  logic           aclr,
  output_writeback_if.slave bus
);

  state_t                state, state_n;
  logic [CountWidth-1:0] pop_remain;
  logic [CountWidth-1:0] write_remain;
  logic [AddrWidth-1:0]  mem_addr;

  logic                  next_valid;
  logic                  next_moves;
  logic                  cur_valid;
  logic [DataWidth-1:0]  cur_data;

  logic                  start_ok;
  logic                  pop;
  logic                  wr_ack;
  logic                  busy_c;
  logic                  done_c;

  assign start_ok = (state == ST_IDLE) && bus.Start;
  assign wr_ack   = cur_valid && bus.MemAck;

  // Pop only when the Next slot is free or is being vacated this cycle
  assign pop = (state == ST_RUN) && (|bus.FifoReady) && (pop_remain != '0) &&
               (!next_valid || next_moves);

  output_writeback_slots #(
    .DataWidth (DataWidth)
  ) u_slots (
    .clk        (clk),
    .aclr       (aclr),
    .push       (pop),
    .push_data  (bus.FifoData),
    .ack        (bus.MemAck),
    .next_valid (next_valid),
    .next_moves (next_moves),
    .cur_valid  (cur_valid),
    .cur_data   (cur_data)
  );

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.Start) begin
          state_n = (bus.NumWords == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        busy_c = 1'b1;
        if (wr_ack && (write_remain == CountWidth'(1))) begin
          state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        busy_c  = 1'b1;
        done_c  = 1'b1;
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Job counters and write address. start_ok only occurs in IDLE, where no
  // pop or ack can happen, so the load never collides with a decrement.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      pop_remain   <= '0;
      write_remain <= '0;
      mem_addr     <= '0;
    end else if (start_ok) begin
      pop_remain   <= bus.NumWords;
      write_remain <= bus.NumWords;
      mem_addr     <= bus.BaseAddr;
    end else begin
      if (pop) begin
        pop_remain <= pop_remain - CountWidth'(1);
      end
      if (wr_ack) begin
        write_remain <= write_remain - CountWidth'(1);
        mem_addr     <= mem_addr + AddrWidth'(1);
      end
    end
  end

  assign bus.Pop2     = pop;
  assign bus.MemWrite = cur_valid;
  assign bus.MemAddr  = mem_addr;
  assign bus.MemData  = cur_data;
  assign bus.Busy     = busy_c;
  assign bus.Done     = done_c;

endmodule
